// File: rtl/uart_echo_tester.sv
// uart_echo_tester: sends a burst of 8N1 test bytes on uart_txd and checks
// each echo received on uart_rxd against the byte that was sent.
// Ports: clk, resetn (async, active low), start, num_bytes (0 = 256), seed,
//   uart_rxd (async in), uart_txd, busy, done (pulse), pass, err_count
//   (saturating), timeout_err (sticky until next start).
// Option: define UART_ECHO_TESTER_LFSR_EN to step bytes with an 8-bit LFSR
//   (x^8+x^6+x^5+x^4+1, seed 0x00 forced to 0x01) instead of +1.
module uart_echo_tester #(
    parameter int CLK_HZ            = 12_000_000,
    parameter int BIT_RATE          = 9600,
    parameter int RESP_TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] num_bytes,
    input  logic [7:0] seed,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       timeout_err
);

    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int TMO  = RESP_TIMEOUT_BITS * CPB;
    localparam int CW   = $clog2(TMO + 1);

    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] TMO_M1  = CW'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_ECHO, CHECK, FINISH
    } state_t;

    typedef enum logic [1:0] {
        R_IDLE, R_START, R_DATA, R_STOP
    } rstate_t;

    // ---------------- byte sequence ----------------
    logic [7:0] cur_byte;
    logic [7:0] seed_l;
    logic [7:0] nxt_byte;

`ifdef UART_ECHO_TESTER_LFSR_EN
    assign seed_l   = (seed == 8'h00) ? 8'h01 : seed;
    assign nxt_byte = {cur_byte[6:0],
                       cur_byte[7] ^ cur_byte[5] ^ cur_byte[4] ^ cur_byte[3]};
`else
    assign seed_l   = seed;
    assign nxt_byte = cur_byte + 8'd1;
`endif

    // ---------------- rx synchroniser ----------------
    // rx_d is one extra stage used only for falling-edge detection.
    logic rx_m, rx_s, rx_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= uart_rxd;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // ---------------- receiver ----------------
    rstate_t       rst;
    logic [CW-1:0] rcnt;
    logic [2:0]    rbit;
    logic [7:0]    rsh;
    logic          rx_valid;
    logic          rx_ferr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst      <= R_IDLE;
            rcnt     <= '0;
            rbit     <= '0;
            rsh      <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            unique case (rst)
                R_IDLE: begin
                    if (rx_d && !rx_s) begin
                        rst  <= R_START;
                        rcnt <= '0;
                    end
                end
                R_START: begin
                    if (rcnt == HALF_M1) begin
                        rcnt <= '0;
                        rbit <= '0;
                        // still high at mid start bit: glitch, drop it
                        rst  <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rcnt == CPB_M1) begin
                        rcnt <= '0;
                        rsh  <= {rx_s, rsh[7:1]};
                        rbit <= rbit + 3'd1;
                        if (rbit == 3'd7) rst <= R_STOP;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (rcnt == CPB_M1) begin
                        rcnt     <= '0;
                        rst      <= R_IDLE;
                        rx_valid <= rx_s;
                        rx_ferr  <= !rx_s;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end
                default: rst <= R_IDLE;
            endcase
        end
    end

    // ---------------- control ----------------
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic [8:0]    rem;
    logic [7:0]    rx_hold;
    logic          rx_pend;

    logic [1:0] inc;
    logic [8:0] sum;
    logic [7:0] err_nxt;

    // Several error sources can land in one cycle; sum then saturate.
    always_comb begin
        inc = 2'd0;
        if (busy && (rx_ferr || (rx_valid && rx_pend)))
            inc = inc + 2'd1;
        if (state == CHECK && rx_hold != cur_byte)
            inc = inc + 2'd1;
        if (state == WAIT_ECHO && !rx_pend && cnt == TMO_M1)
            inc = inc + 2'd1;
        sum     = {1'b0, err_count} + {7'd0, inc};
        err_nxt = sum[8] ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_bit      <= '0;
            tx_sh       <= '0;
            rem         <= '0;
            cur_byte    <= '0;
            rx_hold     <= '0;
            rx_pend     <= 1'b0;
            uart_txd    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == IDLE && start) begin
                rx_pend <= 1'b0;
            end else if (busy && rx_valid) begin
                rx_pend <= 1'b1;
                rx_hold <= rsh;
            end else if (state == CHECK) begin
                rx_pend <= 1'b0;
            end

            if (state == IDLE && start)
                err_count <= '0;
            else
                err_count <= err_nxt;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SEND;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        timeout_err <= 1'b0;
                        rem         <= (num_bytes == 8'd0) ? 9'd256
                                                           : {1'b0, num_bytes};
                        cur_byte    <= seed_l;
                        tx_sh       <= seed_l;
                        uart_txd    <= 1'b0;
                        tx_bit      <= '0;
                        cnt         <= '0;
                    end
                end
                SEND: begin
                    if (cnt == CPB_M1) begin
                        cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            state <= WAIT_ECHO;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            if (tx_bit == 4'd8) begin
                                uart_txd <= 1'b1;
                            end else begin
                                uart_txd <= tx_sh[0];
                                tx_sh    <= {1'b0, tx_sh[7:1]};
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_ECHO: begin
                    if (rx_pend) begin
                        state <= CHECK;
                    end else if (cnt == TMO_M1) begin
                        state       <= FINISH;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CHECK: begin
                    rem <= rem - 9'd1;
                    if (rem == 9'd1) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 8'd0) && !timeout_err;
                    end else begin
                        state    <= SEND;
                        cur_byte <= nxt_byte;
                        tx_sh    <= nxt_byte;
                        uart_txd <= 1'b0;
                        tx_bit   <= '0;
                        cnt      <= '0;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_tester.sv
// tb_uart_echo_tester: random and directed bursts against a software UART
// echo model; expected bytes and error counts come from a sequence model.
module tb_uart_echo_tester;

    localparam int CPB  = 16;
    localparam int RTO  = 20;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] num_bytes;
    logic [7:0] seed;
    logic       uart_rxd;
    logic       uart_txd;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic       timeout_err;

    uart_echo_tester #(
        .CLK_HZ(16),
        .BIT_RATE(1),
        .RESP_TIMEOUT_BITS(RTO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .num_bytes(num_bytes),
        .seed(seed),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit          loop_mode = 1'b1;
    bit          echo_en   = 1'b0;
    bit          stop_bad  = 1'b0;
    bit          glitch_en = 1'b0;
    logic [31:0] cmask     = '0;
    int          fr_idx    = 0;
    logic        rxd_drv   = 1'b1;
    logic [7:0]  tx_q[$];
    logic [7:0]  echo_byte;
    event        ev_echo;

    assign uart_rxd = loop_mode ? uart_txd : rxd_drv;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] nxt_b(input logic [7:0] b);
`ifdef UART_ECHO_TESTER_LFSR_EN
        return {b[6:0], ^(b & 8'hB8)};
`else
        return b + 8'd1;
`endif
    endfunction

    function automatic logic [7:0] first_b(input logic [7:0] s);
`ifdef UART_ECHO_TESTER_LFSR_EN
        return (s == 8'h00) ? 8'h01 : s;
`else
        return s;
`endif
    endfunction

    // Decode every frame on uart_txd by mid-bit sampling.
    initial begin : mon
        logic [7:0] b;
        bit ok;
        forever begin
            @(negedge uart_txd);
            repeat (CPB / 2) @(negedge clk);
            ok = (uart_txd == 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            ok = ok && (uart_txd == 1'b1);
            if (ok) begin
                tx_q.push_back(b);
                if (echo_en) begin
                    echo_byte = b ^ ((cmask[fr_idx % 32]) ? 8'h08 : 8'h00);
                    -> ev_echo;
                end
                fr_idx++;
            end
        end
    end

    // Software UART sending the echo back.
    initial begin : echo
        logic [7:0] v;
        forever begin
            @(ev_echo);
            v = echo_byte;
            if (glitch_en) begin
                rxd_drv = 1'b0;
                @(negedge clk);
                rxd_drv = 1'b1;
                repeat (20) @(negedge clk);
            end
            rxd_drv = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                rxd_drv = v[i];
                repeat (CPB) @(negedge clk);
            end
            rxd_drv = !stop_bad;
            repeat (CPB) @(negedge clk);
            rxd_drv = 1'b1;
        end
    end

    task automatic run(input logic [7:0] sd, input int nb, input bit lp,
                       input logic [31:0] cm, input bit sbad,
                       input bit mute, input bit gl, input int budget,
                       input int poke, output int cyc);
        loop_mode = lp;
        echo_en   = !lp && !mute;
        cmask     = cm;
        stop_bad  = sbad;
        glitch_en = gl;
        fr_idx    = 0;
        rxd_drv   = 1'b1;
        tx_q.delete();
        @(negedge clk);
        num_bytes = nb[7:0];
        seed      = sd;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("busy_high", busy, 1);
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (poke != 0 && cyc == poke) begin
                seed      = 8'h55;
                num_bytes = 8'd1;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", done, 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_low", busy, 0);
        repeat (30) @(negedge clk);
    endtask

    task automatic check_bytes(input logic [7:0] sd, input int nb);
        logic [7:0] e;
        e = first_b(sd);
        chk("n_frames", tx_q.size(), nb);
        for (int i = 0; i < nb && i < tx_q.size(); i++) begin
            chk("tx_byte", tx_q[i], e);
            e = nxt_b(e);
        end
    endtask

    task automatic check_res(input int e_err, input bit e_to);
        chk("err_count", err_count, e_err);
        chk("timeout_err", timeout_err, e_to);
        chk("pass", pass, (e_err == 0 && !e_to));
    endtask

    initial begin : main
        int cyc;
        int nb;
        int e_err;
        logic [7:0] sd;
        logic [31:0] cm;

        resetn    = 1'b0;
        start     = 1'b0;
        num_bytes = 8'd0;
        seed      = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_to", timeout_err, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // loopback, wraps through 0xFF
        run(8'hFE, 3, 1, 0, 0, 0, 0, 3 * 200 + 600, 0, cyc);
        check_res(0, 0);
        after_done();
        check_bytes(8'hFE, 3);

        // second echo has bit 3 flipped
        run(8'h30, 4, 0, 32'h2, 0, 0, 0, 4 * 400 + 600, 0, cyc);
        check_res(1, 0);
        after_done();
        check_bytes(8'h30, 4);

        // no echo at all: abort after first frame
        run(8'h11, 5, 0, 0, 0, 1, 0, 5 * 400 + 600, 0, cyc);
        check_res(1, 1);
        chk("to_cycles_ok",
            (cyc >= (10 + RTO) * CPB && cyc <= (10 + RTO) * CPB + 4), 1);
        after_done();
        chk("to_one_frame", tx_q.size(), 1);

        // echo with stop bit low, then nothing valid arrives
        run(8'hA5, 1, 0, 0, 1, 0, 0, 1000, 0, cyc);
        check_res(2, 1);
        after_done();

        // one-cycle glitch ahead of a good echo
        sd = 8'($urandom);
        run(sd, 2, 0, 0, 0, 0, 1, 2 * 400 + 600, 0, cyc);
        check_res(0, 0);
        after_done();
        check_bytes(sd, 2);

        // random echo corruption
        for (int k = 0; k < 3; k++) begin
            sd    = 8'($urandom);
            nb    = $urandom_range(2, 5);
            cm    = $urandom & ((32'd1 << nb) - 1);
            e_err = $countones(cm);
            run(sd, nb, 0, cm, 0, 0, 0, nb * 400 + 600, 0, cyc);
            check_res(e_err, 0);
            after_done();
            check_bytes(sd, nb);
        end

        // reset in the middle of a frame
        loop_mode = 1'b1;
        echo_en   = 1'b0;
        @(negedge clk);
        num_bytes = 8'd3;
        seed      = 8'h00;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_txd_low", uart_txd, 0);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_txd", uart_txd, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_txd", uart_txd, 1);

        // 256 bytes, start pulsed while busy
        run(8'hC3, 256, 1, 0, 0, 0, 0, 256 * 200 + 600, 1000, cyc);
        check_res(0, 0);
        after_done();
        check_bytes(8'hC3, 256);

        // seed 0x00 handling
        run(8'h00, 1, 1, 0, 0, 0, 0, 800, 0, cyc);
        check_res(0, 0);
        after_done();
        check_bytes(8'h00, 1);
        if (tx_q.size() > 0) begin
`ifdef UART_ECHO_TESTER_LFSR_EN
            chk("seed0_first", tx_q[0], 8'h01);
`else
            chk("seed0_first", tx_q[0], 8'h00);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_echo_tester.md
Name: uart_echo_tester

Overview:
- Host-side initiator for the UART echo path. It transmits a programmable burst of test bytes on its own TX line and receives the echoed bytes on its RX line.
- Each echoed byte is compared against the byte that was sent. The block reports pass/fail, a mismatch count and a timeout flag.
- It has its own bit-level serializer and deserializer, with no submodules. It is used for loopback bring-up on the 12 MHz board and for a self-checking link test against the echo top.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz.
- BIT_RATE, 9600, UART bit rate. CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division, must be >= 4).
- RESP_TIMEOUT_BITS, 20, number of bit periods to wait for an echo after own stop bit ends before declaring timeout.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  begin burst; sampled only in IDLE
- num_bytes  input  8  burst length, latched at start; 0 means 256
- seed  input  8  first test byte, latched at start
- uart_rxd  input  1  echoed serial data, asynchronous to clk
- uart_txd  output  1  serial data out, 8N1, LSB first
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse at burst end
- pass  output  1  valid from done until next start; 1 iff err_count==0 and timeout_err==0
- err_count  output  8  mismatches + framing errors + overruns, saturates at 255
- timeout_err  output  1  sticky until next start; echo not seen in time

Behaviour:
- Reset values: uart_txd=1, busy=0, done=0, pass=0, err_count=0, timeout_err=0. FSM goes to IDLE and the receiver goes idle.
- Reset is asynchronous. Reset mid-burst forces uart_txd high in the same cycle, with no partial-frame completion.
- RX synchronisation: uart_rxd passes through a 2-FF synchroniser with an idle-high reset value.
- Receiver runs independently of the FSM:
  - A high-to-low transition on the synced line starts a frame.
  - The start bit is re-checked at CYCLES_PER_BIT/2. If it is high, the frame is a glitch and is dropped silently.
  - Data bits are sampled at mid-bit, LSB first, then the stop bit is sampled.
  - Stop bit high: the byte goes to rx_hold and rx_pend is set.
  - Stop bit low: framing error, err_count++ when busy, and the byte is discarded.
  - A new valid byte arriving while rx_pend is already set is an overrun: err_count++ and rx_hold is overwritten.
  - Received bytes in IDLE are ignored. rx_pend is cleared on accepted start.
- FSM states IDLE, SEND, WAIT_ECHO, CHECK, FINISH:
  - IDLE: when start=1, latch num_bytes/seed, cur_byte=seed, clear err_count, timeout_err, pass and rx_pend, then go to SEND. start in any other state is ignored.
  - SEND: transmit a frame of start(0), d0..d7, stop(1). Each bit lasts exactly CYCLES_PER_BIT cycles. uart_txd goes low on the first SEND cycle. After the last stop-bit cycle, go to WAIT_ECHO and zero the timeout counter.
  - WAIT_ECHO: if rx_pend, go to CHECK, including when it was set during SEND. Otherwise count bit periods. At RESP_TIMEOUT_BITS periods, set timeout_err, err_count++ and go to FINISH (abort).
  - CHECK (1 cycle): if rx_hold != cur_byte, err_count++. Clear rx_pend. Then decrement remaining:
    - remaining 0: go to FINISH.
    - otherwise: cur_byte=next(cur_byte), i.e. +1 mod 256, and go to SEND.
  - FINISH (1 cycle): done=1, pass updated, then go to IDLE. busy drops in the same cycle FINISH exits.
- err_count increments are saturating. A simultaneous mismatch and framing/overrun in one cycle counts +2, still saturating.
- Back-to-back: no idle gap is inserted between frames beyond WAIT_ECHO/CHECK.

Optional Feature:
- Macro UART_ECHO_TESTER_LFSR_EN.
- Defined: next(cur_byte) is an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0. A seed of 0x00 is replaced by 0x01 at latch.
- Undefined: next(cur_byte) = cur_byte+1 mod 256 and seed is used unmodified.

Test Plan (CLK_HZ=16, BIT_RATE=1 → 16 cycles/bit):
- Reset check: assert resetn=0 mid-frame → uart_txd=1 immediately; busy=0, err_count=0, done=0.
- Direct loopback (uart_rxd=uart_txd), seed=0xFE, num_bytes=3 → frames 0xFE, 0xFF, 0x00 on txd with LSB first; done pulse; pass=1, err_count=0.
- Echo model corrupts 2nd byte (bit 3 flipped), num_bytes=4 → done, err_count=1, pass=0, timeout_err=0.
- uart_rxd held high, num_bytes=5 → timeout_err=1, err_count=1 after 20 bit periods past first stop bit; only one frame sent.
- Echo of 0xA5 with stop bit forced low → framing error: err_count=1, then timeout_err=1 (err_count=2); 1-cycle 0 glitch on rxd → ignored.
- num_bytes=0, loopback → 256 frames, done after 256th CHECK, pass=1; start pulsed while busy → no effect. With UART_ECHO_TESTER_LFSR_EN and seed=0x00, first byte is 0x01.
